// File: rtl/sensor_cond.sv
// Pedal-assist sensor conditioning: cadence period, filtered torque/current,
// and the registered assist-current error term.
module sensor_cond #(
    parameter int          FAST_SIM       = 0,
    parameter logic [11:0] TORQUE_MIN     = 12'h380,
    parameter logic [11:0] LOW_BATT_THRES = 12'hA98
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [11:0]        batt,
    input  logic [11:0]        curr,
    input  logic [11:0]        brake,
    input  logic [11:0]        torque,
    input  logic               cadence_raw,
    output logic [11:0]        avg_curr,
    output logic [11:0]        avg_torque,
    output logic [7:0]         cadence_per,
    output logic               pedaling,
    output logic               low_batt,
    output logic               brake_active,
    output logic signed [12:0] error
);

    localparam logic [9:0]  FILT_LAST = (FAST_SIM != 0) ? 10'd15  : 10'd1023;
    localparam logic [11:0] CURR_LAST = (FAST_SIM != 0) ? 12'd63  : 12'd4095;
    localparam logic [13:0] PRE_LAST  = (FAST_SIM != 0) ? 14'd255 : 14'd16383;

    logic        cad_s1, cad_s2;
    logic        cad_filt, cad_filt_q;
    logic [9:0]  filt_cnt;
    logic        cad_rise;
    logic [11:0] curr_cnt;
    logic        curr_tick;
    logic [13:0] curr_acc;
    logic [13:0] pre_cnt;
    logic        pre_tick;
    logic [7:0]  period_cnt;
    logic [16:0] torq_acc;
    logic [11:0] target;

    // Raw crank input is asynchronous and bouncy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cad_s1     <= 1'b0;
            cad_s2     <= 1'b0;
            cad_filt   <= 1'b0;
            cad_filt_q <= 1'b0;
            filt_cnt   <= '0;
        end else begin
            cad_s1     <= cadence_raw;
            cad_s2     <= cad_s1;
            cad_filt_q <= cad_filt;
            if (cad_s2 != cad_filt) begin
                if (filt_cnt == FILT_LAST) begin
                    cad_filt <= cad_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 10'd1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign cad_rise  = cad_filt & ~cad_filt_q;
    assign curr_tick = (curr_cnt == CURR_LAST);
    assign pre_tick  = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curr_cnt <= '0;
            curr_acc <= '0;
            pre_cnt  <= '0;
        end else begin
            curr_cnt <= curr_tick ? 12'd0 : curr_cnt + 12'd1;
            pre_cnt  <= pre_tick ? 14'd0 : pre_cnt + 14'd1;
            if (curr_tick)
                curr_acc <= curr_acc - {2'b0, curr_acc[13:2]} + {2'b0, curr};
        end
    end

    assign avg_curr = curr_acc[13:2];

    // A rise wins over a coincident prescaler pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt  <= 8'hFF;
            cadence_per <= 8'hFF;
        end else if (cad_rise) begin
            cadence_per <= period_cnt;
            period_cnt  <= 8'h00;
        end else begin
            if (pre_tick && period_cnt != 8'hFF)
                period_cnt <= period_cnt + 8'd1;
            if (period_cnt == 8'hFF)
                cadence_per <= 8'hFF;
        end
    end

    assign pedaling = (cadence_per != 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            torq_acc <= '0;
        end else if (cad_rise) begin
            if (pedaling)
                torq_acc <= torq_acc - {5'b0, torq_acc[16:5]} + {5'b0, torque};
            else
                torq_acc <= {torque, 5'b0};
        end
    end

    assign avg_torque = torq_acc[16:5];

    always_comb begin
        target = '0;
        if (pedaling && !low_batt && !brake_active && avg_torque > TORQUE_MIN)
            target = avg_torque - TORQUE_MIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_batt     <= 1'b0;
            brake_active <= 1'b0;
            error        <= '0;
        end else begin
            low_batt     <= (batt < LOW_BATT_THRES);
            brake_active <= (brake < 12'h800);
            error        <= $signed({1'b0, target} - {1'b0, avg_curr});
        end
    end

endmodule

// File: tb/tb_sensor_cond.sv
// Self-checking bench for sensor_cond (FAST_SIM) against a cycle-stepped
// arithmetic reference model.
module tb_sensor_cond;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [11:0]        batt, curr, brake, torque;
    logic               cadence_raw;
    logic [11:0]        avg_curr, avg_torque;
    logic [7:0]         cadence_per;
    logic               pedaling, low_batt, brake_active;
    logic signed [12:0] error;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    sensor_cond #(
        .FAST_SIM      (1),
        .TORQUE_MIN    (12'h380),
        .LOW_BATT_THRES(12'hA98)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .batt        (batt),
        .curr        (curr),
        .brake       (brake),
        .torque      (torque),
        .cadence_raw (cadence_raw),
        .avg_curr    (avg_curr),
        .avg_torque  (avg_torque),
        .cadence_per (cadence_per),
        .pedaling    (pedaling),
        .low_batt    (low_batt),
        .brake_active(brake_active),
        .error       (error)
    );

    // Reference model state (plain integers)
    bit m_s1, m_s2, m_filt, m_filt_q, m_lb, m_ba;
    int m_run, m_edges, m_cacc, m_tacc, m_pcnt, m_per, m_err;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_filt = 0; m_filt_q = 0; m_lb = 0; m_ba = 0;
        m_run = 0; m_edges = 0; m_cacc = 0; m_tacc = 0;
        m_pcnt = 255; m_per = 255; m_err = 0;
    endtask

    task automatic model_step();
        bit rise;
        bit ped;
        int at;
        int tgt;
        rise = m_filt && !m_filt_q;
        ped  = (m_per != 255);
        at   = m_tacc / 32;
        tgt  = (ped && !m_lb && !m_ba && at > 'h380) ? at - 'h380 : 0;
        m_err = tgt - m_cacc / 4;
        m_lb = (int'(batt) < 'hA98);
        m_ba = (int'(brake) < 'h800);
        if (rise)
            m_tacc = ped ? m_tacc - m_tacc / 32 + int'(torque) : int'(torque) * 32;
        m_edges++;
        if (rise) begin
            m_per  = m_pcnt;
            m_pcnt = 0;
        end else begin
            if (m_pcnt == 255) m_per = 255;
            if (m_edges % 256 == 0 && m_pcnt < 255) m_pcnt++;
        end
        if (m_edges % 64 == 0)
            m_cacc = m_cacc - m_cacc / 4 + int'(curr);
        m_filt_q = m_filt;
        if (m_s2 != m_filt) begin
            m_run++;
            if (m_run == 16) begin
                m_filt = m_s2;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = cadence_raw;
    endtask

    task automatic cyc();
        @(negedge clk);
        if (!rst_n) model_reset();
        else model_step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        batt = 12'hFFF; brake = 12'hFFF; curr = '0; torque = '0;
        cadence_raw = 1'b0;
        repeat (3) cyc();
        n_chk++;
        if (avg_curr !== 12'h000) $display("FAIL rst_avg_curr got %h want 000", avg_curr);
        else n_pass++;
        n_chk++;
        if (avg_torque !== 12'h000) $display("FAIL rst_avg_torque got %h want 000", avg_torque);
        else n_pass++;
        n_chk++;
        if (cadence_per !== 8'hFF) $display("FAIL rst_cadence_per got %h want ff", cadence_per);
        else n_pass++;
        n_chk++;
        if (pedaling !== 1'b0) $display("FAIL rst_pedaling got %b want 0", pedaling);
        else n_pass++;
        n_chk++;
        if (low_batt !== 1'b0 || brake_active !== 1'b0)
            $display("FAIL rst_flags got %b%b want 00", low_batt, brake_active);
        else n_pass++;
        n_chk++;
        if (error !== 13'h0000) $display("FAIL rst_error got %h want 0000", error);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_curr_filter();
        curr = 12'h400;
        for (int i = 0; i < 41 * 64; i++) begin
            cyc();
            n_chk++;
            if (avg_curr !== 12'(m_cacc / 4))
                $display("FAIL curr_ramp got %h want %h", avg_curr, 12'(m_cacc / 4));
            else n_pass++;
        end
        n_chk++;
        if (avg_curr < 12'h3FC || avg_curr > 12'h400)
            $display("FAIL curr_settle got %h want 3fc..400", avg_curr);
        else n_pass++;
    endtask

    task automatic test_random_curr();
        for (int i = 0; i < 10 * 64; i++) begin
            curr = 12'($urandom_range(0, 4095));
            cyc();
            n_chk++;
            if (avg_curr !== 12'(m_cacc / 4) || error !== 13'(m_err))
                $display("FAIL curr_rand got %h/%h want %h/%h",
                         avg_curr, error, 12'(m_cacc / 4), 13'(m_err));
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < 48; c++) begin
                cadence_raw = (c < 8);
                torque = 12'($urandom_range(0, 4095));
                cyc();
                n_chk++;
                if (cadence_per !== 8'hFF || pedaling !== 1'b0 ||
                    avg_torque !== 12'(m_tacc / 32))
                    $display("FAIL glitch got per=%h ped=%b tq=%h want ff 0 %h",
                             cadence_per, pedaling, avg_torque, 12'(m_tacc / 32));
                else n_pass++;
            end
        end
    endtask

    task automatic test_cadence();
        rst_n = 1'b0;
        curr = '0; torque = 12'h700; cadence_raw = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        repeat (100) cyc();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 2560; c++) begin
                cadence_raw = (c < 20);
                if (p == 2 && c == 0) torque = 12'($urandom_range(0, 4095));
                cyc();
                n_chk++;
                if (avg_torque !== 12'(m_tacc / 32) || cadence_per !== 8'(m_per) ||
                    error !== 13'(m_err))
                    $display("FAIL cadence got tq=%h per=%h err=%h want %h %h %h",
                             avg_torque, cadence_per, error,
                             12'(m_tacc / 32), 8'(m_per), 13'(m_err));
                else n_pass++;
                if (p == 0 && c == 2559) begin
                    n_chk++;
                    if (avg_torque !== 12'h700 || pedaling !== 1'b0)
                        $display("FAIL seed got tq=%h ped=%b want 700 0",
                                 avg_torque, pedaling);
                    else n_pass++;
                end
                if (p == 1 && c == 2559) begin
                    n_chk++;
                    if (cadence_per !== 8'h0A || pedaling !== 1'b1)
                        $display("FAIL period got per=%h ped=%b want 0a 1",
                                 cadence_per, pedaling);
                    else n_pass++;
                    n_chk++;
                    if (error !== 13'h0380)
                        $display("FAIL assist_err got %h want 0380", error);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_brake();
        curr = 12'h200;
        for (int i = 0; i < 45 * 64; i++) begin
            cyc();
            n_chk++;
            if (error !== 13'(m_err) || avg_curr !== 12'(m_cacc / 4))
                $display("FAIL brake_pre got %h/%h want %h/%h",
                         error, avg_curr, 13'(m_err), 12'(m_cacc / 4));
            else n_pass++;
        end
        brake = 12'h100;
        cyc();
        n_chk++;
        if (brake_active !== 1'b1) $display("FAIL brake_on got %b want 1", brake_active);
        else n_pass++;
        cyc();
        n_chk++;
        if (error !== 13'h1E00) $display("FAIL brake_err got %h want 1e00", error);
        else n_pass++;
        brake = 12'h7FF;
        cyc();
        n_chk++;
        if (brake_active !== 1'b1) $display("FAIL brake_7ff got %b want 1", brake_active);
        else n_pass++;
        brake = 12'h800;
        cyc();
        n_chk++;
        if (brake_active !== 1'b0) $display("FAIL brake_800 got %b want 0", brake_active);
        else n_pass++;
        brake = 12'hFFF;
        cyc();
    endtask

    task automatic test_low_batt();
        batt = 12'hA97;
        cyc();
        n_chk++;
        if (low_batt !== 1'b1) $display("FAIL lowbatt_a97 got %b want 1", low_batt);
        else n_pass++;
        cyc();
        n_chk++;
        if (error !== 13'h1E00) $display("FAIL lowbatt_err got %h want 1e00", error);
        else n_pass++;
        batt = 12'hA98;
        cyc();
        n_chk++;
        if (low_batt !== 1'b0) $display("FAIL lowbatt_a98 got %b want 0", low_batt);
        else n_pass++;
        for (int i = 0; i < 60; i++) begin
            batt  = 12'($urandom_range(12'hA80, 12'hAB0));
            brake = 12'($urandom_range(12'h7E0, 12'h820));
            cyc();
            n_chk++;
            if (low_batt !== m_lb || brake_active !== m_ba || error !== 13'(m_err))
                $display("FAIL flags_rand got %b%b %h want %b%b %h",
                         low_batt, brake_active, error, m_lb, m_ba, 13'(m_err));
            else n_pass++;
        end
        batt = 12'hFFF; brake = 12'hFFF;
        cyc(); cyc();
    endtask

    task automatic test_reset_mid();
        n_chk++;
        if (pedaling !== 1'b1 || avg_curr === 12'h000)
            $display("FAIL premid got ped=%b cur=%h want 1 nonzero", pedaling, avg_curr);
        else n_pass++;
        rst_n = 1'b0;
        cyc();
        n_chk++;
        if (avg_curr !== 12'h000 || avg_torque !== 12'h000 || error !== 13'h0000)
            $display("FAIL midrst_acc got %h %h %h want 000 000 0000",
                     avg_curr, avg_torque, error);
        else n_pass++;
        n_chk++;
        if (cadence_per !== 8'hFF || pedaling !== 1'b0 ||
            low_batt !== 1'b0 || brake_active !== 1'b0)
            $display("FAIL midrst_flags got %h %b%b%b want ff 000",
                     cadence_per, pedaling, low_batt, brake_active);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_stop();
        bit stopped;
        torque = 12'($urandom_range(12'h400, 12'hFFF));
        for (int c = 0; c < 2600; c++) begin
            cadence_raw = (c < 20) || (c >= 2560 && c < 2580);
            cyc();
            n_chk++;
            if (cadence_per !== 8'(m_per) || avg_torque !== 12'(m_tacc / 32))
                $display("FAIL repedal got %h %h want %h %h",
                         cadence_per, avg_torque, 8'(m_per), 12'(m_tacc / 32));
            else n_pass++;
        end
        n_chk++;
        if (pedaling !== 1'b1) $display("FAIL repedal_on got %b want 1", pedaling);
        else n_pass++;
        stopped = 0;
        cadence_raw = 1'b0;
        for (int i = 0; i < 70000 && !stopped; i++) begin
            cyc();
            n_chk++;
            if (cadence_per !== 8'(m_per))
                $display("FAIL stop_track got %h want %h", cadence_per, 8'(m_per));
            else n_pass++;
            if (m_per == 255) stopped = 1;
        end
        n_chk++;
        if (cadence_per !== 8'hFF || pedaling !== 1'b0)
            $display("FAIL stopped got per=%h ped=%b want ff 0", cadence_per, pedaling);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_curr_filter();
        test_random_curr();
        test_glitch();
        test_cadence();
        test_brake();
        test_low_batt();
        test_reset_mid();
        test_stop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sensor_cond.md
SENSOR_COND -- requirements
Module: sensor_cond

Interface
REQ-001 SHALL have parameter FAST_SIM, default 0, nonzero shortens all timers for simulation.
REQ-002 SHALL have parameter TORQUE_MIN, default 12'h380, torque deadband subtracted before target-current calculation.
REQ-003 SHALL have parameter LOW_BATT_THRES, default 12'hA98, battery level below which assist is disabled.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports batt, curr, brake, torque  input  12 each  unsigned conversions from the A2D interface; they may change on any clock.
REQ-007 SHALL have port cadence_raw  input  1  crank pulse, asynchronous to clk and bouncy.
REQ-008 SHALL have port avg_curr  output  12  filtered motor current.
REQ-009 SHALL have port avg_torque  output  12  filtered crank torque.
REQ-010 SHALL have port cadence_per  output  8  crank period in prescaler ticks; 8'hFF means stopped.
REQ-011 SHALL have port pedaling  output  1  high when cadence_per != 8'hFF.
REQ-012 SHALL have port low_batt  output  1  registered (batt < LOW_BATT_THRES).
REQ-013 SHALL have port brake_active  output  1  registered (brake < 12'h800).
REQ-014 SHALL have port error  output  13  signed, target current minus avg_curr.

Function
REQ-015 cadence_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Glitch filter: filtered cadence SHALL take the synchronized value only after it differs from the filtered value for 1024 consecutive clocks (16 when FAST_SIM); a shorter mismatch resets the filter count.
REQ-017 cad_rise SHALL be a single-cycle pulse on each 0->1 transition of the filtered cadence.
REQ-018 Current sample tick SHALL pulse once every 4096 clocks (64 when FAST_SIM), free-running from reset.
REQ-019 On each current tick, 14-bit curr_acc SHALL update to curr_acc - curr_acc[13:2] + curr; avg_curr = curr_acc[13:2].
REQ-020 Period prescaler SHALL pulse once every 16384 clocks (256 when FAST_SIM).
REQ-021 8-bit period_cnt SHALL increment on each prescaler pulse and saturate at 8'hFF.
REQ-022 On cad_rise, cadence_per SHALL load period_cnt, and period_cnt SHALL clear to 0 in the same cycle.
REQ-023 When period_cnt reaches 8'hFF without cad_rise, cadence_per SHALL become 8'hFF on the next clock (crank stopped).
REQ-024 If cad_rise and a prescaler pulse coincide, cadence_per SHALL load the pre-increment period_cnt and period_cnt SHALL become 0.
REQ-025 On cad_rise while pedaling=1, 17-bit torq_acc SHALL update to torq_acc - torq_acc[16:5] + torque; avg_torque = torq_acc[16:5].
REQ-026 On cad_rise while pedaling=0, torq_acc SHALL be seeded with {torque,5'b0} so avg_torque equals torque on the next clock.
REQ-027 target SHALL be avg_torque - TORQUE_MIN when avg_torque > TORQUE_MIN, else 0; target SHALL be forced to 0 when pedaling=0, low_batt=1 or brake_active=1.
REQ-028 error SHALL be registered as {1'b0,target} - {1'b0,avg_curr}, 13-bit two's complement, updated every clock (one-cycle latency from its operands).
REQ-029 low_batt and brake_active SHALL be registered compares, one-cycle latency from batt/brake.

Reset
REQ-030 On rst_n low, all accumulators, counters, filter state and outputs SHALL clear to 0, except cadence_per and period_cnt which SHALL reset to 8'hFF (pedaling=0).
REQ-031 Reset assertion mid-operation SHALL abort filtering immediately; no partial accumulator state survives reset.

Verification
REQ-032 FAST_SIM=1, curr held 12'h400 from reset -> avg_curr rises monotonically to within 4 of 12'h400 after 40 current ticks.
REQ-033 FAST_SIM=1, 8-clock pulses on cadence_raw -> no cad_rise, cadence_per stays 8'hFF; 20-clock-high pulses every 2560 clocks -> cadence_per settles at 8'h0A, pedaling=1.
REQ-034 First cad_rise with torque=12'h700 while stopped -> avg_torque=12'h700 next clock; with TORQUE_MIN=12'h380 and avg_curr=0, error=13'h0380.
REQ-035 Pedaling, then brake=12'h100 -> brake_active=1 after one clock, error = -avg_curr (e.g. avg_curr 12'h200 -> error 13'h1E00).
REQ-036 batt=12'hA97 -> low_batt=1 and target=0; batt=12'hA98 -> low_batt=0.
REQ-037 Cadence stopped for 255 prescaler pulses -> cadence_per=8'hFF, pedaling=0; rst_n pulse mid-pedal -> all outputs at reset values while rst_n low.
